// File: rtl/mult_accum_unsigned_if.sv
// Operand-tracking and result handshake bundle between the multiplier feed, the accumulator and its consumer.
// slave is the accumulator side; master is the producer/consumer side that drives operands and accepts sums.
interface mult_accum_unsigned_if #(
    parameter int WIDTHP   = 40,
    parameter int WIDTHACC = 48,
    parameter int LENW     = 8
);
    logic                in_valid;
    logic                in_last;
    logic [WIDTHP-1:0]   RES;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTHACC-1:0] acc_out;
    logic [LENW-1:0]     cnt_out;
    logic                out_sat;
    logic                drop;

    modport slave (
        input  in_valid, in_last, RES, out_ready,
        output out_valid, acc_out, cnt_out, out_sat, drop
    );

    modport master (
        output in_valid, in_last, RES, out_ready,
        input  out_valid, acc_out, cnt_out, out_sat, drop
    );
endinterface

// File: rtl/mult_accum_unsigned.sv
// Dot-product accumulator behind a fixed-latency multiplier; MULT_ACCUM_SAT_EN selects saturating sums.
// Latency: result registered one edge after the last product appears on RES (LATENCY+1 from in_valid).
// Backpressure: never stalls upstream; a sum completing while the output is held is dropped and pulses drop.
module mult_accum_unsigned #(
    parameter int WIDTHP   = 40,
    parameter int WIDTHACC = 48,
    parameter int LATENCY  = 5,
    parameter int LENW     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_accum_unsigned_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

`ifdef MULT_ACCUM_SAT_EN
    localparam int SUMW = WIDTHACC + 1;
`else
    localparam int SUMW = WIDTHACC;
`endif

    logic [LATENCY-1:0]  vld_sr;
    logic [LATENCY-1:0]  last_sr;
    logic                p_valid;
    logic                p_last;
    logic                done;

    logic [0:0]          state;
    logic [WIDTHACC-1:0] acc;
    logic [LENW-1:0]     cnt;

    logic [WIDTHACC-1:0] base;
    logic [SUMW-1:0]     sum;
    logic [WIDTHACC-1:0] acc_nxt;
    logic [LENW-1:0]     cnt_nxt;
    logic                sat_nxt;

    logic                out_valid_q;
    logic [WIDTHACC-1:0] acc_out_q;
    logic [LENW-1:0]     cnt_out_q;
    logic                out_sat_q;
    logic                drop_q;

    assign p_valid = vld_sr[LATENCY-1];
    assign p_last  = last_sr[LATENCY-1];
    assign done    = p_valid & p_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr[0]  <= bus.in_valid;
            last_sr[0] <= bus.in_valid & bus.in_last;
            for (int i = 1; i < LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    // A vector always starts from zero, so IDLE adds RES to nothing.
    assign base = (state == RUN) ? acc : '0;
    assign sum  = SUMW'(base) + SUMW'(bus.RES);

`ifdef MULT_ACCUM_SAT_EN
    logic sat;

    assign sat_nxt = ((state == RUN) & sat) | sum[WIDTHACC];
    assign acc_nxt = sat_nxt ? '1 : sum[WIDTHACC-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (p_valid) begin
            sat <= p_last ? 1'b0 : sat_nxt;
        end
    end
`else
    assign sat_nxt = 1'b0;
    assign acc_nxt = sum;
`endif

    assign cnt_nxt = (state == IDLE) ? LENW'(1) :
                     (&cnt)          ? cnt : cnt + LENW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else if (p_valid) begin
            if (p_last) begin
                state <= IDLE;
                acc   <= '0;
                cnt   <= '0;
            end else begin
                state <= RUN;
                acc   <= acc_nxt;
                cnt   <= cnt_nxt;
            end
        end
    end

    // Accepting the held sum frees the register in the same edge, so that case loads instead of dropping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            cnt_out_q   <= '0;
            out_sat_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= done & out_valid_q & ~bus.out_ready;
            if (done && (!out_valid_q || bus.out_ready)) begin
                out_valid_q <= 1'b1;
                acc_out_q   <= acc_nxt;
                cnt_out_q   <= cnt_nxt;
                out_sat_q   <= sat_nxt;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.cnt_out   = cnt_out_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.drop      = drop_q;
endmodule

// File: tb/tb_mult_accum_unsigned.sv
// Directed bench for mult_accum_unsigned with a 5-stage multiplier model feeding RES and a result scoreboard.
// Build with or without MULT_ACCUM_SAT_EN; expected saturation results follow the same macro.
module tb_mult_accum_unsigned;
    localparam int WIDTHP   = 40;
    localparam int WIDTHACC = 41;
    localparam int LATENCY  = 5;
    localparam int LENW     = 8;
    localparam logic [63:0] MAXACC = (64'd1 << WIDTHACC) - 64'd1;

    typedef struct {
        logic [63:0] acc;
        int          cnt;
        bit          sat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] a_op;
    logic [23:0] b_op;
    logic [WIDTHP-1:0] mpipe [LATENCY];

    exp_t        sb [$];
    logic [63:0] vec_sum;
    int          vec_cnt;
    int          n_cmp;
    int          n_err;
    int          drop_cnt;

    mult_accum_unsigned_if #(.WIDTHP(WIDTHP), .WIDTHACC(WIDTHACC), .LENW(LENW)) bus ();

    mult_accum_unsigned #(
        .WIDTHP(WIDTHP), .WIDTHACC(WIDTHACC), .LATENCY(LATENCY), .LENW(LENW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream multiplier: operands driven in one cycle give the product on RES LATENCY edges later.
    always @(posedge clk) begin
        mpipe[0] <= WIDTHP'(a_op) * WIDTHP'(b_op);
        for (int i = 1; i < LATENCY; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.RES = mpipe[LATENCY-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.drop === 1'b1) drop_cnt++;
        if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'(bus.acc_out), 64'hdead);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("acc_out", 64'(bus.acc_out), e.acc);
                check("cnt_out", 64'(bus.cnt_out), 64'(e.cnt));
                check("out_sat", 64'(bus.out_sat), 64'(e.sat));
            end
        end
    end

    task automatic term(input logic [15:0] a, input logic [23:0] b, input bit last, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        a_op = a;
        b_op = b;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        vec_sum = vec_sum + 64'(a) * 64'(b);
        vec_cnt++;
        if (last) begin
            e.cnt = (vec_cnt > 255) ? 255 : vec_cnt;
`ifdef MULT_ACCUM_SAT_EN
            e.sat = (vec_sum > MAXACC);
            e.acc = e.sat ? MAXACC : vec_sum;
`else
            e.sat = 1'b0;
            e.acc = vec_sum & MAXACC;
`endif
            if (push) sb.push_back(e);
            vec_sum = '0;
            vec_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; drop_cnt = 0;
        vec_sum = '0; vec_cnt = 0;
        rst_n = 1'b0;
        a_op = '0; b_op = '0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_acc_out",   64'(bus.acc_out),   64'd0);
        check("rst_cnt_out",   64'(bus.cnt_out),   64'd0);
        check("rst_out_sat",   64'(bus.out_sat),   64'd0);
        check("rst_drop",      64'(bus.drop),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single term: out_valid must appear exactly after the sixth edge.
        term(16'd3, 24'd5, 1'b1, 1'b1);
        idle(5);
        check("single_not_early", 64'(bus.out_valid), 64'd0);
        idle(1);
        check("single_valid", 64'(bus.out_valid), 64'd1);
        check("single_acc",   64'(bus.acc_out),   64'd15);
        bus.out_ready = 1'b1;
        idle(3);

        // Four back-to-back terms, then the same with two idle cycles between terms.
        for (int i = 1; i <= 4; i++) term(16'(i), 24'(i), i == 4, 1'b1);
        idle(8);
        for (int i = 1; i <= 4; i++) begin
            term(16'(i), 24'(i), i == 4, 1'b1);
            if (i != 4) idle(2);
        end
        idle(8);

        // Backpressure: first sum held, second dropped.
        bus.out_ready = 1'b0;
        term(16'd2, 24'd3, 1'b1, 1'b1);
        term(16'd7, 24'd1, 1'b1, 1'b0);
        idle(7);
        check("bp_valid_held", 64'(bus.out_valid), 64'd1);
        check("bp_acc_held",   64'(bus.acc_out),   64'd6);
        check("bp_drop_once",  64'(drop_cnt),      64'd1);
        bus.out_ready = 1'b1;
        idle(1);
        check("bp_valid_fall", 64'(bus.out_valid), 64'd0);
        idle(2);

        // Accept of a held 10 coincides with completion of {4*4}.
        bus.out_ready = 1'b0;
        term(16'd2, 24'd5, 1'b1, 1'b1);
        idle(8);
        check("simul_held_acc", 64'(bus.acc_out), 64'd10);
        term(16'd4, 24'd4, 1'b1, 1'b1);
        idle(5);
        bus.out_ready = 1'b1;
        idle(1);
        check("simul_valid", 64'(bus.out_valid), 64'd1);
        check("simul_acc",   64'(bus.acc_out),   64'd16);
        check("simul_drop",  64'(bus.drop),      64'd0);
        idle(3);

        // Saturation boundary with WIDTHACC=41.
        for (int i = 0; i < 3; i++) term(16'hFFFF, 24'hFFFFFF, i == 2, 1'b1);
        idle(8);

        // Term counter saturates at 255.
        for (int i = 0; i < 257; i++) term(16'd1, 24'd1, i == 256, 1'b1);
        idle(8);

        // Reset with a held result and a partial vector in flight.
        bus.out_ready = 1'b0;
        term(16'd5, 24'd5, 1'b1, 1'b1);
        idle(7);
        check("prerst_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 3; i++) term(16'd1, 24'd1, 1'b0, 1'b0);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_drop",  64'(bus.drop),      64'd0);
        sb.delete();
        vec_sum = '0;
        vec_cnt = 0;
        bus.out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        term(16'd2, 24'd2, 1'b1, 1'b1);
        idle(8);

        for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        check("total_drops",        64'(drop_cnt),  64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mult_accum_unsigned.md
Name: mult_accum_unsigned

Overview:
- Downstream consumer of the unsigned 16x24 multiplier (5-cycle pipeline: operands sampled at edge 0, product on RES after edge 5).
- Tracks operand validity alongside the multiplier pipeline and sums products into a wide accumulator to form dot products.
- Presents each completed sum through a valid/ready output register.
- Multiplier cannot stall, so this block never back-pressures upstream; results that cannot be held are dropped and flagged.

Parameters:
- WIDTHP, 40, product width (width of RES).
- WIDTHACC, 48, accumulator and result width; must be >= WIDTHP.
- LATENCY, 5, cycles from operands presented to the multiplier until the product is on RES.
- LENW, 8, width of the term counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  high in the cycle A/B are driven to the multiplier.
- in_last  in  1  qualifies in_valid; marks the final term of a vector.
- RES  in  WIDTHP  product from the multiplier.
- out_valid  out  1  result register holds an unread sum.
- out_ready  in  1  consumer accepts the result.
- acc_out  out  WIDTHACC  completed sum.
- cnt_out  out  LENW  number of terms in acc_out.
- out_sat  out  1  accumulator saturated during this vector.
- drop  out  1  one-cycle pulse: a completed sum was discarded.

Behaviour:
- Reset (async, rst_n=0):
  - valid/last delay lines, accumulator, term count, sat flag, out_valid, acc_out, cnt_out, out_sat and drop all go to 0.
  - In-flight products are discarded; the partial sum is lost.
  - First valid term after release starts a fresh vector.
- Delay line:
  - in_valid and in_last (last qualified by valid) shift through LATENCY stages, giving p_valid/p_last aligned with RES.
  - in_last with in_valid=0 is ignored.
- Accumulate FSM, states IDLE and RUN:
  - IDLE, p_valid & !p_last: acc<=RES zero-extended, cnt<=1, sat<=0; go to RUN.
  - IDLE, p_valid & p_last: deliver a single-term result of RES, cnt 1; stay IDLE.
  - RUN, p_valid: acc<=acc+RES, cnt<=cnt+1.
  - RUN, p_valid & p_last: deliver acc+RES; clear acc/cnt/sat; go to IDLE.
  - No p_valid: hold state.
  - Gaps between terms of a vector are allowed.
- Arithmetic:
  - Sum computed at WIDTHACC+1 bits.
  - Carry out saturates the sum (see optional feature).
  - cnt saturates at 2^LENW-1; no wrap.
- Delivery, after the edge following p_valid & p_last (out_valid high 6 cycles after in_valid sampled when LATENCY=5):
  - Output empty, or out_valid & out_ready in that same cycle: load acc_out/cnt_out/out_sat and set out_valid=1. Simultaneous accept+load is not a drop.
  - out_valid=1 and out_ready=0: the new sum is discarded, drop=1 for one cycle, and the held result is unchanged.
- Output handshake:
  - out_valid & out_ready with no new load: out_valid<=0 next edge.
  - acc_out is stable while out_valid=1 and out_ready=0.
- Throughput: one term per cycle, unconditionally.

Optional Feature:
- Macro: MULT_ACCUM_SAT_EN.
- Defined: a carry out of WIDTHACC bits clamps acc to all-ones. Further terms in the vector keep it clamped. sat is set and reported on out_sat.
- Undefined: the accumulator wraps modulo 2^WIDTHACC, and out_sat is tied to 0.

Test Plan:
- Single term: in_valid=1, in_last=1, A=3, B=5 at edge 0 -> out_valid=1 after edge 6, acc_out=15, cnt_out=1, out_sat=0, drop never asserted.
- Four back-to-back terms 1*1, 2*2, 3*3, 4*4 (last on the 4th), out_ready=1 -> one result: acc_out=30, cnt_out=4. Repeat with 2 idle cycles between terms -> same result.
- Backpressure: out_ready=0; vector {2*3} then vector {7*1} -> acc_out=6 held, drop pulses once at the second completion; then out_ready=1 -> 6 accepted, out_valid falls, 7 is never presented.
- Simultaneous: out_valid=1 holding 10, out_ready=1 in the same cycle the next vector {4*4} completes -> 10 accepted, acc_out=16 with out_valid=1 next cycle, drop=0.
- Saturation with WIDTHACC=41: three terms of 0xFFFF*0xFFFFFF. With MULT_ACCUM_SAT_EN -> acc_out=2^41-1, out_sat=1, cnt_out=3. Without it -> acc_out=(3*0xFFFEFF0001) mod 2^41, out_sat=0.
- Reset mid-vector: 3 terms of a vector in flight, pulse rst_n low asynchronously -> out_valid=0 and drop=0 immediately. After release, vector {2*2} -> acc_out=4, cnt_out=1.
